// File: rtl/hazard_scoreboard_if.sv
// Decode-side handshake bundle for the hazard scoreboard: issue info and
// source operands in, stall/forward/statistics out.
interface hazard_scoreboard_if #(
    parameter int REG_ADDR = 5,
    parameter int NUM_SRC  = 2,
    parameter int DEPTH    = 3,
    parameter int CNT_W    = 32
);
    localparam int SEL_W = $clog2(DEPTH + 1);

    logic                        i_issue_valid;
    logic [REG_ADDR-1:0]         i_issue_rd;
    logic                        i_issue_regwrite;
    logic                        i_issue_mem2reg;
    logic [NUM_SRC*REG_ADDR-1:0] i_src_addr;
    logic [NUM_SRC-1:0]          i_src_used;
    logic                        i_flush;
    logic                        o_stall_d;
    logic [NUM_SRC*SEL_W-1:0]    o_fwd_sel;
    logic [CNT_W-1:0]            o_stall_cnt;

    modport slave (
        input  i_issue_valid, i_issue_rd, i_issue_regwrite, i_issue_mem2reg,
        input  i_src_addr, i_src_used, i_flush,
        output o_stall_d, o_fwd_sel, o_stall_cnt
    );

    modport master (
        output i_issue_valid, i_issue_rd, i_issue_regwrite, i_issue_mem2reg,
        output i_src_addr, i_src_used, i_flush,
        input  o_stall_d, o_fwd_sel, o_stall_cnt
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// Hazard/forwarding unit: shift scoreboard of in-flight register writes,
// per-source forwarding selects, decode stall and a saturating stall counter.
module hazard_scoreboard #(
    parameter int REG_ADDR   = 5,
    parameter int NUM_SRC    = 2,
    parameter int DEPTH      = 3,
    parameter int ALU_READY  = 1,
    parameter int LOAD_READY = 2,
    parameter int FWD_EN     = 1,
    parameter int CNT_W      = 32
) (
    input logic            i_clk,
    input logic            i_reset,
    hazard_scoreboard_if.slave bus
);
    localparam int SEL_W = $clog2(DEPTH + 1);
    // Writeback entry writes the regfile through, so it never needs a stall.
    localparam logic [DEPTH-1:0] LAST_BIT = DEPTH'(1) << (DEPTH - 1);

    logic [DEPTH-1:0]         r_vld;
    logic [DEPTH-1:0]         r_ld;
    logic [REG_ADDR-1:0]      r_rd [DEPTH];
    logic [CNT_W-1:0]         r_cnt;

    logic [REG_ADDR-1:0]      w_src   [NUM_SRC];
    logic [DEPTH-1:0]         w_match [NUM_SRC];
    logic [DEPTH-1:0]         w_young [NUM_SRC];
    logic [DEPTH-1:0]         w_rdy;
    logic [NUM_SRC-1:0]       w_need;
    logic [NUM_SRC*SEL_W-1:0] w_fwd;
    logic                     w_stall;

    // Per-entry result availability and per-source match vectors
    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            w_rdy[k] = r_ld[k] ? (k >= LOAD_READY) : (k >= ALU_READY);
        end
        for (int i = 0; i < NUM_SRC; i++) begin
            w_src[i]   = bus.i_src_addr[i*REG_ADDR +: REG_ADDR];
            w_match[i] = '0;
            for (int k = 0; k < DEPTH; k++) begin
                w_match[i][k] = bus.i_src_used[i] && (w_src[i] != '0) &&
                                r_vld[k] && (r_rd[k] == w_src[i]);
            end
        end
    end

    // Youngest-match selection, forwarding select and stall decision
    always_comb begin
        w_fwd  = '0;
        w_need = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            // Lowest set bit is the youngest producer.
            w_young[i] = w_match[i] & ~(w_match[i] - DEPTH'(1));
            if (FWD_EN != 0) begin
                w_need[i] = |(w_young[i] & ~w_rdy);
                for (int k = 0; k < DEPTH; k++) begin
                    w_fwd[i*SEL_W +: SEL_W] = w_fwd[i*SEL_W +: SEL_W] |
                        ((w_young[i][k] & w_rdy[k]) ? SEL_W'(k + 1) : SEL_W'(0));
                end
            end else begin
                w_need[i] = |(w_match[i] & ~LAST_BIT);
            end
        end
        w_stall = bus.i_issue_valid & ~bus.i_flush & (|w_need);
    end

    // Scoreboard shift; stall or flush loads a bubble into execute
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_vld <= '0;
            r_ld  <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                r_rd[k] <= '0;
            end
        end else begin
            r_vld[0] <= bus.i_issue_valid & bus.i_issue_regwrite & ~w_stall & ~bus.i_flush;
            r_rd[0]  <= bus.i_issue_rd;
            r_ld[0]  <= bus.i_issue_mem2reg;
            for (int k = 1; k < DEPTH; k++) begin
                r_vld[k] <= r_vld[k-1];
                r_rd[k]  <= r_rd[k-1];
                r_ld[k]  <= r_ld[k-1];
            end
        end
    end

    // Saturating count of stalled decode cycles
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cnt <= '0;
        end else if (w_stall && (r_cnt != '1)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end else begin
            r_cnt <= r_cnt;
        end
    end

    assign bus.o_stall_d   = w_stall;
    assign bus.o_fwd_sel   = w_fwd;
    assign bus.o_stall_cnt = r_cnt;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: a forwarding instance and a no-forwarding
// 4-bit-counter instance share stimulus; a producer-list model feeds a scoreboard.
module tb_hazard_scoreboard;
    localparam int  DP    = 3;
    localparam longint MAXA = 64'h0000_0000_FFFF_FFFF;
    localparam longint MAXB = 15;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    hazard_scoreboard_if #(.REG_ADDR(5), .NUM_SRC(2), .DEPTH(3), .CNT_W(32)) ifa ();
    hazard_scoreboard_if #(.REG_ADDR(5), .NUM_SRC(2), .DEPTH(3), .CNT_W(4))  ifb ();

    hazard_scoreboard #(.REG_ADDR(5), .NUM_SRC(2), .DEPTH(3), .ALU_READY(1),
                        .LOAD_READY(2), .FWD_EN(1), .CNT_W(32))
        dut_a (.i_clk(clk), .i_reset(reset), .bus(ifa.slave));
    hazard_scoreboard #(.REG_ADDR(5), .NUM_SRC(2), .DEPTH(3), .ALU_READY(1),
                        .LOAD_READY(2), .FWD_EN(0), .CNT_W(4))
        dut_b (.i_clk(clk), .i_reset(reset), .bus(ifb.slave));

    typedef struct { bit valid; int rd; bit rw; bit ld; int s0; int s1;
                     bit [1:0] used; bit flush; bit rst; } in_t;
    typedef struct { int rd; bit load; int age; } prod_t;
    typedef struct { bit stall; int sel0; int sel1; } res_t;
    typedef struct { int cyc; bit sa; int a0; int a1; longint ca;
                     bit sb; int b0; int b1; longint cb; } exp_t;

    prod_t qa[$];
    prod_t qb[$];
    exp_t  expq[$];
    longint cnt_a, cnt_b;
    in_t   prv;
    res_t  pa, pb;
    bit    known;
    int    cyc;
    int    n_tests, n_fail;

    // Age 0 = execute; a producer is visible for DP cycles after issue.
    function automatic res_t ref_eval(input prod_t q[$], input bit fwd_en, input in_t s);
        res_t r;
        int   addr[2];
        int   sel[2];
        bit   need;
        need = 1'b0;
        addr[0] = s.s0;
        addr[1] = s.s1;
        for (int i = 0; i < 2; i++) begin
            bit found, ld, early;
            int age;
            found = 1'b0; ld = 1'b0; early = 1'b0; age = 0; sel[i] = 0;
            if (s.used[i] && addr[i] != 0) begin
                for (int j = q.size() - 1; j >= 0; j--) begin
                    if (q[j].rd == addr[i]) begin
                        if (!found) begin
                            found = 1'b1; age = q[j].age; ld = q[j].load;
                        end
                        if (q[j].age < DP - 1) early = 1'b1;
                    end
                end
            end
            if (fwd_en) begin
                if (found) begin
                    if (age >= (ld ? 2 : 1)) sel[i] = age + 1;
                    else need = 1'b1;
                end
            end else if (early) begin
                need = 1'b1;
            end
        end
        r.stall = s.valid && !s.flush && need;
        r.sel0  = sel[0];
        r.sel1  = sel[1];
        return r;
    endfunction

    function automatic in_t mk(input bit v, input int rd, input bit rw, input bit ld,
                               input int s0, input int s1, input bit [1:0] used,
                               input bit fl, input bit rst);
        in_t s;
        s.valid = v; s.rd = rd; s.rw = rw; s.ld = ld; s.s0 = s0; s.s1 = s1;
        s.used = used; s.flush = fl; s.rst = rst;
        return s;
    endfunction

    task automatic apply(input in_t s);
        reset = s.rst;
        ifa.i_issue_valid = s.valid;      ifb.i_issue_valid = s.valid;
        ifa.i_issue_rd = 5'(s.rd);        ifb.i_issue_rd = 5'(s.rd);
        ifa.i_issue_regwrite = s.rw;      ifb.i_issue_regwrite = s.rw;
        ifa.i_issue_mem2reg = s.ld;       ifb.i_issue_mem2reg = s.ld;
        ifa.i_src_addr = {5'(s.s1), 5'(s.s0)};
        ifb.i_src_addr = {5'(s.s1), 5'(s.s0)};
        ifa.i_src_used = s.used;          ifb.i_src_used = s.used;
        ifa.i_flush = s.flush;            ifb.i_flush = s.flush;
    endtask

    // One clock: retire the model to the new edge, drive, predict, enqueue
    task automatic step(input in_t s);
        @(posedge clk);
        cyc++;
        if (prv.rst) begin
            qa.delete(); qb.delete(); cnt_a = 0; cnt_b = 0; known = 1'b1;
        end else begin
            for (int j = 0; j < qa.size(); j++) qa[j].age++;
            for (int j = 0; j < qb.size(); j++) qb[j].age++;
            while (qa.size() > 0 && qa[0].age >= DP) void'(qa.pop_front());
            while (qb.size() > 0 && qb[0].age >= DP) void'(qb.pop_front());
            if (prv.valid && prv.rw && !prv.flush) begin
                if (!pa.stall) qa.push_back('{prv.rd, prv.ld, 0});
                if (!pb.stall) qb.push_back('{prv.rd, prv.ld, 0});
            end
            if (pa.stall && cnt_a < MAXA) cnt_a++;
            if (pb.stall && cnt_b < MAXB) cnt_b++;
        end
        #1;
        apply(s);
        pa = ref_eval(qa, 1'b1, s);
        pb = ref_eval(qb, 1'b0, s);
        if (known)
            expq.push_back('{cyc, pa.stall, pa.sel0, pa.sel1, cnt_a,
                             pb.stall, pb.sel0, pb.sel1, cnt_b});
        prv = s;
    endtask

    task automatic chk(input string name, input int c, input logic [63:0] got, input longint want);
        n_tests++;
        if (got !== 64'(want)) begin
            n_fail++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, c, got, want);
        end
    endtask

    // Monitor: compare on the falling edge whenever a prediction is pending
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (expq.size() > 0) begin
                e = expq.pop_front();
                chk("stall_a", e.cyc, 64'(ifa.o_stall_d),       longint'(e.sa));
                chk("sel0_a",  e.cyc, 64'(ifa.o_fwd_sel[1:0]),  e.a0);
                chk("sel1_a",  e.cyc, 64'(ifa.o_fwd_sel[3:2]),  e.a1);
                chk("cnt_a",   e.cyc, 64'(ifa.o_stall_cnt),     e.ca);
                chk("stall_b", e.cyc, 64'(ifb.o_stall_d),       longint'(e.sb));
                chk("sel0_b",  e.cyc, 64'(ifb.o_fwd_sel[1:0]),  e.b0);
                chk("sel1_b",  e.cyc, 64'(ifb.o_fwd_sel[3:2]),  e.b1);
                chk("cnt_b",   e.cyc, 64'(ifb.o_stall_cnt),     e.cb);
            end
        end
    end

    initial begin
        in_t idle;
        in_t s;
        n_tests = 0; n_fail = 0; cyc = 0; known = 1'b0;
        cnt_a = 0; cnt_b = 0;
        idle = mk(1'b0, 0, 1'b0, 1'b0, 0, 0, 2'b00, 1'b0, 1'b0);
        prv  = mk(1'b0, 0, 1'b0, 1'b0, 0, 0, 2'b00, 1'b0, 1'b1);
        pa = '{1'b0, 0, 0};
        pb = '{1'b0, 0, 0};
        apply(prv);

        repeat (2) step(mk(1'b0, 0, 1'b0, 1'b0, 0, 0, 2'b00, 1'b0, 1'b1));
        repeat (2) step(idle);
        // ALU x5 then consumer at distance 1
        step(mk(1'b1, 5, 1'b1, 1'b0, 0, 0, 2'b00, 1'b0, 1'b0));
        repeat (3) step(mk(1'b1, 8, 1'b1, 1'b0, 5, 0, 2'b01, 1'b0, 1'b0));
        repeat (3) step(idle);
        // load x6 then consumer
        step(mk(1'b1, 6, 1'b1, 1'b1, 0, 0, 2'b00, 1'b0, 1'b0));
        repeat (3) step(mk(1'b1, 9, 1'b1, 1'b0, 6, 0, 2'b01, 1'b0, 1'b0));
        repeat (3) step(idle);
        // two x7 writers, youngest in entry1 wins; x0 never matches
        repeat (2) step(mk(1'b1, 7, 1'b1, 1'b0, 0, 0, 2'b00, 1'b0, 1'b0));
        step(mk(1'b1, 3, 1'b0, 1'b0, 0, 0, 2'b00, 1'b0, 1'b0));
        step(mk(1'b1, 10, 1'b1, 1'b0, 7, 7, 2'b11, 1'b0, 1'b0));
        step(mk(1'b1, 0, 1'b1, 1'b0, 0, 0, 2'b00, 1'b0, 1'b0));
        step(mk(1'b1, 11, 1'b1, 1'b0, 0, 0, 2'b11, 1'b0, 1'b0));
        repeat (3) step(idle);
        // flush on a would-be stall cycle
        step(mk(1'b1, 12, 1'b1, 1'b1, 0, 0, 2'b00, 1'b0, 1'b0));
        step(mk(1'b1, 13, 1'b1, 1'b0, 12, 0, 2'b01, 1'b1, 1'b0));
        repeat (2) step(mk(1'b1, 14, 1'b1, 1'b0, 12, 0, 2'b01, 1'b0, 1'b0));
        repeat (3) step(idle);

        for (int n = 0; n < 3000; n++) begin
            s = mk($urandom_range(0, 9) != 0, $urandom_range(0, 7), $urandom_range(0, 3) != 0,
                   $urandom_range(0, 2) == 0, $urandom_range(0, 7), $urandom_range(0, 7),
                   2'($urandom_range(0, 3)), $urandom_range(0, 9) == 0,
                   $urandom_range(0, 49) == 0);
            step(s);
        end

        // saturate the 4-bit counter, then reset in the middle of a stall
        step(idle);
        for (int n = 0; n < 8; n++) begin
            step(mk(1'b1, 6, 1'b1, 1'b1, 0, 0, 2'b00, 1'b0, 1'b0));
            repeat (2) step(mk(1'b1, 9, 1'b0, 1'b0, 6, 0, 2'b01, 1'b0, 1'b0));
        end
        step(mk(1'b1, 6, 1'b1, 1'b1, 0, 0, 2'b00, 1'b0, 1'b0));
        step(mk(1'b1, 9, 1'b1, 1'b0, 6, 0, 2'b01, 1'b0, 1'b0));
        step(mk(1'b1, 9, 1'b1, 1'b0, 6, 0, 2'b01, 1'b0, 1'b1));
        repeat (3) step(mk(1'b1, 9, 1'b1, 1'b0, 6, 6, 2'b11, 1'b0, 1'b0));

        @(negedge clk);
        #1;
        n_tests++;
        if (expq.size() != 0) begin
            n_fail++;
            $display("FAIL drain pending=%0d expected=0", expq.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
